// File: rtl/irq_ctrl.sv
// irq_ctrl -- round-robin interrupt controller with a two-word slave register map.
//
// Register map (word addresses, only bit 0 decoded):
//   word 0 write : per-source enable mask (low SRCCOUNT bits)
//   word 0 read  : CLAIM -- while the CPU is being signalled, returns
//                  {1, zeros, selected index} and acknowledges that source;
//                  otherwise returns 0 with no side effect
//   word 1 read  : pending mask (src_stb_i & enable), zero-extended
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   wb_cyc_i/stb_i/we_i/addr_i/...   slave request (registered, executed one
//                                    cycle later, acked the cycle after that)
//   wb_bsy_o, wb_ack_o, wb_dat_o     slave response
//   wb_mapsz_o                       size in bytes of the register window
//   src_stb_i / src_rdy_o            per-source level request / ready (a
//                                    one-cycle low on src_rdy_o acknowledges)
//   cpu_stb_o                        interrupt request to the CPU
module irq_ctrl #(
    parameter int ARCHBITSZ = 16,
    parameter int SRCCOUNT  = 2,
    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8),
    localparam int IDXW      = (SRCCOUNT > 1) ? $clog2(SRCCOUNT) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [ADDRBITSZ-1:0]   wb_addr_i,
    input  logic [ARCHBITSZ/8-1:0] wb_sel_i,
    input  logic [ARCHBITSZ-1:0]   wb_dat_i,
    output logic                   wb_bsy_o,
    output logic                   wb_ack_o,
    output logic [ARCHBITSZ-1:0]   wb_dat_o,
    output logic [ARCHBITSZ-1:0]   wb_mapsz_o,
    input  logic [SRCCOUNT-1:0]    src_stb_i,
    output logic [SRCCOUNT-1:0]    src_rdy_o,
    output logic                   cpu_stb_o
);

    typedef enum logic [1:0] {IDLE, SIGNAL, ACK, HOLD} state_t;

    // Registered bus request (execution stage)
    logic                 req_q, we_q, addr_q;
    logic [SRCCOUNT-1:0]  wdat_q;
    logic                 ack_q;
    logic [ARCHBITSZ-1:0] rdat_q, rdat_d;

    logic [SRCCOUNT-1:0]  en_q;
    logic [SRCCOUNT-1:0]  pending;

    state_t               state_q, state_d;
    logic [IDXW-1:0]      sel_q, sel_d, last_q, last_d;
    logic                 hold_q, hold_d;
    logic [IDXW-1:0]      scan_idx;
    logic                 scan_hit;
    logic                 claim;

    // Byte selects and undecoded bits have no function in this block.
    logic unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_addr_i[ADDRBITSZ-1:1], wb_dat_i[ARCHBITSZ-1:SRCCOUNT]};

    assign pending    = src_stb_i & en_q;
    assign claim      = req_q && !we_q && !addr_q && (state_q == SIGNAL);

    assign wb_bsy_o   = 1'b0;
    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = rdat_q;
    assign wb_mapsz_o = ARCHBITSZ'(2 * (ARCHBITSZ / 8));
    assign cpu_stb_o  = (state_q == SIGNAL);

    always_comb begin
        src_rdy_o = '1;
        if (state_q == ACK) src_rdy_o[sel_q] = 1'b0;
    end

    // Round-robin scan: first pending source after the last one served,
    // wrapping from SRCCOUNT-1 back to 0.
    always_comb begin
        int i;
        i        = 0;
        scan_idx = last_q;
        scan_hit = 1'b0;
        for (int k = 1; k <= SRCCOUNT; k++) begin
            i = int'(last_q) + k;
            if (i >= SRCCOUNT) i = i - SRCCOUNT;
            if (!scan_hit && pending[IDXW'(i)]) begin
                scan_hit = 1'b1;
                scan_idx = IDXW'(i);
            end
        end
    end

    // Read data for the access executing this cycle.
    always_comb begin
        rdat_d = '0;
        if (!we_q) begin
            if (addr_q) begin
                rdat_d = ARCHBITSZ'(pending);
            end else if (state_q == SIGNAL) begin
                rdat_d[ARCHBITSZ-1] = 1'b1;
                rdat_d[IDXW-1:0]    = sel_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q  <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= 1'b0;
            wdat_q <= '0;
            ack_q  <= 1'b0;
            rdat_q <= '0;
            en_q   <= '0;
        end else begin
            req_q  <= wb_cyc_i && wb_stb_i;
            we_q   <= wb_we_i;
            addr_q <= wb_addr_i[0];
            wdat_q <= wb_dat_i[SRCCOUNT-1:0];
            ack_q  <= req_q;
            rdat_q <= req_q ? rdat_d : '0;
            // FSM sees en_q before this write lands, so a same-cycle
            // transition uses the old mask.
            if (req_q && we_q && !addr_q) en_q <= wdat_q;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (scan_hit) begin
                    sel_d   = scan_idx;
                    last_d  = scan_idx;
                    state_d = SIGNAL;
                end
            end
            // selidx stays latched here even if the source or its enable drops.
            SIGNAL: if (claim) state_d = ACK;
            ACK: begin
                hold_d  = 1'b0;
                state_d = HOLD;
            end
            // Two quiet cycles so the acknowledged source can release its request.
            HOLD: begin
                if (hold_q) state_d = IDLE;
                else        hold_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= IDXW'(SRCCOUNT - 1);
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter ARCHBITSZ, default 16: data bus width; 16, 32 or 64.
REQ-002 Parameter SRCCOUNT, default 2: number of interrupt sources; 1 to ARCHBITSZ-1.
REQ-003 Derived ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).
REQ-004 clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  slave request qualifiers.
REQ-007 wb_addr_i  in  ADDRBITSZ  word address; only bit 0 decoded.
REQ-008 wb_sel_i  in  ARCHBITSZ/8  byte select; ignored, full-word access.
REQ-009 wb_dat_i  in  ARCHBITSZ  write data.
REQ-010 wb_bsy_o  out  1  tied 0.
REQ-011 wb_ack_o  out  1  access acknowledge.
REQ-012 wb_dat_o  out  ARCHBITSZ  read data, valid while wb_ack_o high.
REQ-013 wb_mapsz_o  out  ARCHBITSZ  constant 2*(ARCHBITSZ/8).
REQ-014 src_stb_i  in  SRCCOUNT  per-source request, level, held by source until acknowledged.
REQ-015 src_rdy_o  out  SRCCOUNT  per-source ready; falling edge acknowledges that source.
REQ-016 cpu_stb_o  out  1  interrupt request to CPU.

Function
REQ-017 Bus: stb=wb_cyc_i&&wb_stb_i registered with we, addr, dat in cycle N; access executes in N+1; wb_ack_o high in N+2; one ack per request cycle.
REQ-018 Word 0 write: enable[SRCCOUNT-1:0] <= wb_dat[SRCCOUNT-1:0]; upper bits ignored.
REQ-019 Word 0 read (CLAIM): in SIGNAL returns {1'b1 at bit ARCHBITSZ-1, zeros, selidx}; otherwise returns 0 with no side effect.
REQ-020 Word 1 read: returns src_stb_i & enable, zero-extended; word 1 write ignored.
REQ-021 pending = src_stb_i & enable, evaluated every cycle.
REQ-022 FSM states IDLE, SIGNAL, ACK, HOLD.
REQ-023 IDLE: if pending nonzero, selidx <= first set bit scanning lastidx+1 upward, wrapping SRCCOUNT-1 to 0; lastidx <= selidx; next SIGNAL.
REQ-024 SIGNAL: cpu_stb_o=1; CLAIM read executing this cycle -> ACK, cpu_stb_o low from next cycle.
REQ-025 ACK: src_rdy_o[selidx]=0 for exactly one cycle, all other bits 1; next HOLD.
REQ-026 HOLD: 2 cycles, no scan, lets acknowledged source drop its request; then IDLE.
REQ-027 Outside ACK, src_rdy_o all ones; cpu_stb_o high only in SIGNAL.
REQ-028 selidx latched; source dropping stb or enable cleared during SIGNAL does not cancel it; CLAIM still returns it and ACK still pulses it.
REQ-029 Enable write and state transition in same cycle: transition uses pre-write enable.
REQ-030 SRCCOUNT=1: round-robin degenerates to index 0.
REQ-031 Worst-case IDLE-to-SIGNAL latency 1 cycle; minimum service period IDLE..IDLE 5 cycles plus CPU claim delay.

Reset
REQ-032 rst_i high: state IDLE, enable 0, lastidx SRCCOUNT-1 (first scan starts at 0), selidx 0, cpu_stb_o 0, src_rdy_o all ones, wb_ack_o 0, read-data register 0.
REQ-033 Reset in SIGNAL/ACK/HOLD aborts: no further rdy pulse, cpu_stb_o low next cycle, in-flight bus access not acked.

Verification (ARCHBITSZ=32, SRCCOUNT=4)
REQ-034 Write enable=0xF, raise src_stb_i=0b0100 -> cpu_stb_o high 1 cycle later; CLAIM returns 0x80000002; src_rdy_o=0b1011 one cycle; cpu_stb_o 0.
REQ-035 src_stb_i held 0b1111, four claims -> indices 0,1,2,3, then 0 (wrap).
REQ-036 enable=0b0010, src_stb_i=0b0001 -> cpu_stb_o stays 0; word 1 reads 0; enable=0b0011 -> claim returns 0x80000000.
REQ-037 CLAIM read in IDLE -> 0x00000000, ack 2 cycles after request, no src_rdy_o pulse.
REQ-038 In SIGNAL selidx=3, drop src_stb_i[3] and write enable=0 -> claim still 0x80000003, src_rdy_o[3] pulses.
REQ-039 Assert rst_i during ACK -> src_rdy_o 0xF, cpu_stb_o 0, enable 0, next request served from index 0.
